// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state codes,
// the round-robin pick function and a frame-length helper.
package uart_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   // Bit counter wide enough for up to 9 data bits or 2 stop bits.
   localparam int CNT_W = 4;

   function automatic int f_frame_bits(input int data_bits, input int parity_en,
                                       input int stop_bits);
      return 1 + data_bits + ((parity_en != 0) ? 1 : 0) + stop_bits;
   endfunction

   // First set bit of req at or above ptr, wrapping within n requesters.
   function automatic logic [3:0] f_rr_pick(input logic [15:0] req, input logic [3:0] ptr,
                                            input int n);
      logic [3:0] pick;
      logic       found;
      int         idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         idx = int'(ptr) + i;
         if (idx >= n) idx = idx - n;
         if (!found && (i < n) && req[idx[3:0]]) begin
            pick  = idx[3:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick with a registered rotating priority pointer.
// The pointer moves past the winner only when the pick is actually taken.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               take,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] ptr;

   assign winner = IDX_W'(f_rr_pick(16'(req), 4'(ptr), NUM_REQ));
   assign valid  = |req;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (take) begin
         ptr <= (winner == LAST) ? '0 : winner + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: picks one requester per frame and
// serialises start, data (LSB first), optional parity and stop bits.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int OWN_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst,
   input  logic                         i_Baud_Tick,
   input  logic [NUM_REQ-1:0]           i_Req,
   input  logic [NUM_REQ*DATA_BITS-1:0] i_Data,
   output logic [NUM_REQ-1:0]           o_Gnt,
   output logic [OWN_W-1:0]             o_Owner,
   output logic                         o_Busy,
   output logic                         o_Tx
);

   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   logic [2:0]           state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_bit;
   logic [OWN_W-1:0]     owner;
   logic                 tx;
   logic [OWN_W-1:0]     winner;
   logic                 any_req;
   logic                 grant_point;
   logic                 grant;
   logic [DATA_BITS-1:0] win_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (OWN_W)
   ) u_arb (
      .clk    (i_Clk),
      .rst    (i_Rst),
      .req    (i_Req),
      .take   (grant),
      .winner (winner),
      .valid  (any_req)
   );

   // A new frame may start only from idle or on the tick that ends the last stop bit.
   assign grant_point = (state == IDLE) || ((state == STOP) && (bit_cnt == STOP_LAST));
   assign grant       = !i_Rst && i_Baud_Tick && any_req && grant_point;
   assign win_data    = i_Data[int'(winner)*DATA_BITS +: DATA_BITS];

   // NOTE: default first so a combinational output never holds a stale value (no latch).
   always_comb begin
      o_Gnt = '0;
      if (grant) o_Gnt[winner] = 1'b1;
   end

   // NOTE: every register, including the shift register, has a defined reset value; tx resets high.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
         owner     <= '0;
         tx        <= 1'b1;
      end else if (i_Baud_Tick) begin
         if (grant) begin
            state     <= START;
            tx        <= 1'b0;
            shift_reg <= win_data;
            par_bit   <= (^win_data) ^ (PARITY_ODD != 0);
            owner     <= winner;
            bit_cnt   <= '0;
         end else begin
            case (state)
               START: begin
                  state     <= DATA;
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= '0;
               end
               DATA: begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        tx    <= par_bit;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     tx        <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= bit_cnt + 1'b1;
                  end
               end
               PARITY: begin
                  state   <= STOP;
                  tx      <= 1'b1;
                  bit_cnt <= '0;
               end
               STOP: begin
                  if (bit_cnt == STOP_LAST) begin
                     state   <= IDLE;
                     tx      <= 1'b1;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end

   assign o_Tx    = tx;
   assign o_Owner = owner;
   assign o_Busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (plain 8N1 and 8O2) checked every
// cycle against a frame-list reference model, plus directed literal scenarios.
module tb_uart_tx_scheduler;

   localparam int NR   = 4;
   localparam int DB   = 8;
   localparam int MAXF = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic [NR-1:0]    req  [2];
   logic [NR*DB-1:0] data [2];

   logic [NR-1:0] gnt_a, gnt_b;
   logic [1:0]    owner_a, owner_b;
   logic          busy_a, busy_b, tx_a, tx_b;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: current frame as a plain bit list and the bit index on the line.
   int            m_pos   [2];
   int            m_ptr   [2];
   int            m_owner [2];
   logic          m_frame [2][MAXF];
   logic [NR-1:0] m_gnt_prev [2];
   bit            hold [2];
   bit            rand_mode = 1'b0;

   bit tx_log_a[$];
   bit tx_log_b[$];
   int gnt_log_a[$];
   int gnt_log_b[$];

   always #5 clk = ~clk;

   uart_tx_scheduler #(
      .NUM_REQ(NR), .DATA_BITS(DB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
   ) dut_a (
      .i_Clk(clk), .i_Rst(rst), .i_Baud_Tick(tick), .i_Req(req[0]), .i_Data(data[0]),
      .o_Gnt(gnt_a), .o_Owner(owner_a), .o_Busy(busy_a), .o_Tx(tx_a)
   );

   uart_tx_scheduler #(
      .NUM_REQ(NR), .DATA_BITS(DB), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)
   ) dut_b (
      .i_Clk(clk), .i_Rst(rst), .i_Baud_Tick(tick), .i_Req(req[1]), .i_Data(data[1]),
      .o_Gnt(gnt_b), .o_Owner(owner_b), .o_Busy(busy_b), .o_Tx(tx_b)
   );

   function automatic int par_en(input int m);  return (m == 1) ? 1 : 0; endfunction
   function automatic int par_odd(input int m); return (m == 1) ? 1 : 0; endfunction
   function automatic int stops(input int m);   return (m == 1) ? 2 : 1; endfunction
   function automatic int flen(input int m);    return 1 + DB + par_en(m) + stops(m); endfunction

   function automatic logic [NR-1:0] gnt_of(input int m);   return (m == 0) ? gnt_a : gnt_b; endfunction
   function automatic logic [1:0]    owner_of(input int m); return (m == 0) ? owner_a : owner_b; endfunction
   function automatic logic          busy_of(input int m);  return (m == 0) ? busy_a : busy_b; endfunction
   function automatic logic          tx_of(input int m);    return (m == 0) ? tx_a : tx_b; endfunction

   // Winner this cycle from the rules, or -1 if no grant happens.
   function automatic int model_pick(input int m);
      if (!tick || (req[m] == '0)) return -1;
      if (!((m_pos[m] < 0) || (m_pos[m] == flen(m) - 1))) return -1;
      for (int i = 0; i < NR; i++) begin
         int k;
         k = (m_ptr[m] + i) % NR;
         if (req[m][k]) return k;
      end
      return -1;
   endfunction

   task automatic load_frame(input int m, input logic [DB-1:0] d);
      int idx;
      m_frame[m][0] = 1'b0;
      for (int i = 0; i < DB; i++) m_frame[m][1+i] = d[i];
      idx = 1 + DB;
      if (par_en(m) != 0) begin
         m_frame[m][idx] = (^d) ^ (par_odd(m) != 0);
         idx++;
      end
      for (int i = 0; i < stops(m); i++) m_frame[m][idx+i] = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_pos[m]      = -1;
         m_ptr[m]      = 0;
         m_owner[m]    = 0;
         m_gnt_prev[m] = '0;
      end
   endtask

   // Model advance on each active edge (or asynchronously on reset).
   initial begin
      int w;
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            for (int m = 0; m < 2; m++) begin
               w = model_pick(m);
               m_gnt_prev[m] = (w >= 0) ? (NR'(1) << w) : '0;
               if (tick) begin
                  if (w >= 0) begin
                     load_frame(m, data[m][w*DB +: DB]);
                     m_pos[m]   = 0;
                     m_owner[m] = w;
                     m_ptr[m]   = (w + 1) % NR;
                  end else if (m_pos[m] >= 0) begin
                     m_pos[m]++;
                     if (m_pos[m] == flen(m)) m_pos[m] = -1;
                  end
               end
            end
         end
      end
   end

   // Compare process: all outputs of both instances on every falling edge outside reset.
   initial begin
      int w;
      logic [NR-1:0] eg;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int m = 0; m < 2; m++) begin
               w  = model_pick(m);
               eg = (w >= 0) ? (NR'(1) << w) : '0;
               check($sformatf("gnt%0d", m), 32'(gnt_of(m)), 32'(eg));
               check($sformatf("tx%0d", m), 32'(tx_of(m)),
                     32'((m_pos[m] < 0) ? 1'b1 : m_frame[m][m_pos[m]]));
               check($sformatf("busy%0d", m), 32'(busy_of(m)), 32'(m_pos[m] >= 0));
               check($sformatf("owner%0d", m), 32'(owner_of(m)), 32'(m_owner[m]));
            end
            if (tick) begin
               tx_log_a.push_back(tx_a);
               tx_log_b.push_back(tx_b);
            end
            for (int k = 0; k < NR; k++) begin
               if (gnt_a[k]) gnt_log_a.push_back(k);
               if (gnt_b[k]) gnt_log_b.push_back(k);
            end
         end
      end
   end

   // One clock; afterwards requesters react to the grant just issued.
   task automatic step();
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < NR; k++) begin
            if (m_gnt_prev[m][k]) begin
               if (rand_mode ? ($urandom_range(0, 1) == 1) : hold[m])
                  data[m][k*DB +: DB] = DB'($urandom);
               else
                  req[m][k] = 1'b0;
            end else if (rand_mode && !req[m][k] && ($urandom_range(0, 4) == 0)) begin
               req[m][k] = 1'b1;
               data[m][k*DB +: DB] = DB'($urandom);
            end
         end
      end
   endtask

   task automatic cycle(input logic t);
      tick = t;
      step();
   endtask

   task automatic run_ticks(input int n, input int period);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < period - 1; j++) cycle(1'b0);
         cycle(1'b1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0);
      cycle(1'b0);
      rst = 1'b0;
      cycle(1'b0);
   endtask

   task automatic clear_logs();
      tx_log_a.delete();
      tx_log_b.delete();
      gnt_log_a.delete();
      gnt_log_b.delete();
   endtask

   initial begin
      logic [9:0]  v10;
      logic [11:0] v12;
      logic [2:0]  v3;
      req[0] = '0; req[1] = '0; data[0] = '0; data[1] = '0;
      hold[0] = 1'b0; hold[1] = 1'b0;

      // Reset state
      cycle(1'b0);
      cycle(1'b0);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_gnt", 32'(gnt_a), 32'd0);
      check("rst_owner", 32'(owner_a), 32'd0);
      check("rst_tx_b", 32'(tx_b), 32'd1);
      rst = 1'b0;
      cycle(1'b0);

      // Single request, 8'hA5, tick every 16 cycles
      clear_logs();
      data[0][7:0] = 8'hA5;
      req[0] = 4'b0001;
      run_ticks(12, 16);
      check("single_gnt_cycles", 32'(gnt_log_a.size()), 32'd1);
      if (gnt_log_a.size() > 0) check("single_gnt_idx", 32'(gnt_log_a[0]), 32'd0);
      check("single_tick_count", 32'(tx_log_a.size()), 32'd12);
      v10 = '0;
      for (int i = 0; i < 10; i++) if (i + 1 < tx_log_a.size()) v10[9-i] = tx_log_a[i+1];
      check("single_frame", 32'(v10), 32'(10'b0101001011));
      check("single_busy_end", 32'(busy_a), 32'd0);

      // Round-robin with all four held high
      do_reset();
      clear_logs();
      hold[0] = 1'b1;
      for (int k = 0; k < NR; k++) data[0][k*DB +: DB] = DB'($urandom);
      req[0] = 4'b1111;
      run_ticks(42, 4);
      hold[0] = 1'b0;
      req[0]  = '0;
      check("rr_count", 32'(gnt_log_a.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < gnt_log_a.size()) check($sformatf("rr_order%0d", i), 32'(gnt_log_a[i]), 32'(i % 4));
      if (tx_log_a.size() > 11) check("rr_contig", 32'(tx_log_a[11]), 32'd0);
      run_ticks(12, 4);

      // Pointer skip: after granting 0, 1001 gives 3 then 0
      do_reset();
      data[0][7:0] = 8'h11;
      req[0] = 4'b0001;
      run_ticks(1, 4);
      clear_logs();
      data[0][7:0]   = 8'h22;
      data[0][31:24] = 8'h33;
      req[0] = 4'b1001;
      run_ticks(25, 4);
      check("skip_count", 32'(gnt_log_a.size()), 32'd2);
      if (gnt_log_a.size() > 1) begin
         check("skip_first", 32'(gnt_log_a[0]), 32'd3);
         check("skip_second", 32'(gnt_log_a[1]), 32'd0);
      end
      run_ticks(12, 4);

      // Odd parity, two stop bits, data 8'h03 on instance b
      clear_logs();
      data[1][7:0] = 8'h03;
      req[1] = 4'b0001;
      run_ticks(15, 8);
      check("par_gnt_cycles", 32'(gnt_log_b.size()), 32'd1);
      v12 = '0;
      for (int i = 0; i < 12; i++) if (i + 1 < tx_log_b.size()) v12[11-i] = tx_log_b[i+1];
      check("par_frame", 32'(v12), 32'(12'b011000000111));
      check("par_busy_end", 32'(busy_b), 32'd0);

      // Reset during data bit 4 (bit 4 of A5 is 0)
      data[0][7:0] = 8'hA5;
      req[0] = 4'b0001;
      run_ticks(6, 4);
      cycle(1'b0);
      check("mid_bit4", 32'(tx_a), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", 32'(tx_a), 32'd1);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      cycle(1'b0);
      cycle(1'b0);
      rst = 1'b0;
      clear_logs();
      data[0][15:8] = 8'h3C;
      req[0] = 4'b0010;
      run_ticks(13, 4);
      check("post_rst_gnt_cycles", 32'(gnt_log_a.size()), 32'd1);
      if (gnt_log_a.size() > 0) check("post_rst_gnt_idx", 32'(gnt_log_a[0]), 32'd1);
      v10 = '0;
      for (int i = 0; i < 10; i++) if (i + 1 < tx_log_a.size()) v10[9-i] = tx_log_a[i+1];
      check("post_rst_frame", 32'(v10), 32'(10'b0001111001));
      check("post_rst_owner", 32'(owner_a), 32'd1);

      // Request pulse without a tick
      clear_logs();
      cycle(1'b0);
      req[0] = 4'b0100;
      cycle(1'b0); cycle(1'b0); cycle(1'b0);
      req[0] = '0;
      cycle(1'b0); cycle(1'b0);
      run_ticks(3, 4);
      check("notick_gnt", 32'(gnt_log_a.size()), 32'd0);
      v3 = '0;
      for (int i = 0; i < 3; i++) if (i < tx_log_a.size()) v3[i] = tx_log_a[i];
      check("notick_tx_log", 32'(v3), 32'd7);
      check("notick_tx", 32'(tx_a), 32'd1);

      // Randomised traffic, including a continuously high tick
      rand_mode = 1'b1;
      for (int seg = 0; seg < 10; seg++) begin
         int period;
         period = ((seg % 3) == 0) ? 1 : int'($urandom_range(2, 8));
         for (int c = 0; c < 300; c++)
            cycle((period == 1) ? 1'b1 : ($urandom_range(0, period - 1) == 0));
      end
      rand_mode = 1'b0;
      req[0] = '0;
      req[1] = '0;
      run_ticks(14, 2);
      check("drain_busy_a", 32'(busy_a), 32'd0);
      check("drain_busy_b", 32'(busy_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
